// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues one request at a time over req/gnt/rvalid,
// and buffers returned words toward IF/ID, discarding responses that a redirect has made stale.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        busy
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = BUF_DEPTH[CW:0];

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t         state_q;
    logic [31:0]    pc_q;
    logic [31:0]    req_pc_q;
    entry_t         buf_q [BUF_DEPTH];
    logic [PW-1:0]  wptr_q;
    logic [PW-1:0]  rptr_q;
    logic [CW-1:0]  count_q;

    logic [CW:0]    occupancy;
    logic           accept;
    logic           push;
    logic           pop;
    entry_t         head;
    logic           unused_rpc_lo;

    assign unused_rpc_lo = ^redirect_pc[1:0];

    assign busy      = (state_q != FETCH);
    // The outstanding request reserves a slot so its response can always be pushed.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, busy};
    assign imem_req  = ~rst & (state_q == FETCH) & ~redirect_valid & (occupancy < DEPTH_W);
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_gnt;

    assign push      = (state_q == WAIT) & imem_rvalid & ~redirect_valid;
    assign if_valid  = (count_q != '0);
    assign pop       = if_valid & ~stall & ~redirect_valid;

    assign head      = buf_q[rptr_q];
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            pc_q    <= {redirect_pc[31:2], 2'b00};
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            // A response still in flight belongs to the old path and must be swallowed.
            case (state_q)
                FETCH:   state_q <= FETCH;
                WAIT:    state_q <= imem_rvalid ? FETCH : DRAIN;
                DRAIN:   state_q <= imem_rvalid ? FETCH : DRAIN;
                default: state_q <= FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (accept) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: state_q <= FETCH;
            endcase

            if (push) begin
                buf_q[wptr_q] <= '{pc: req_pc_q, instr: imem_rdata};
                wptr_q        <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        push |-> ({1'b0, count_q} < DEPTH_W));

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        (imem_req & ~imem_gnt) |=> (imem_addr == $past(imem_addr)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then a long randomized run with random memory timing.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        busy;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Stimulus controls
    logic        drv_rst = 1'b1, drv_stall = 1'b0, drv_redir = 1'b0;
    logic [31:0] drv_rpc = '0;
    logic [31:0] key = '0;
    int          gnt_pct = 100, lat_min = 1, lat_max = 1;
    bit          start_log = 0;

    // Memory model
    bit          mem_pend = 0;
    int          mem_wait = 0;
    logic [31:0] mem_addr = '0;
    logic        req_s = 1'b0;
    logic [31:0] addr_s = '0;

    // Reference model: next fetch pc, buffered instructions, outstanding kind (0 none, 1 live, 2 stale)
    logic [31:0] m_pc = '0;
    logic [31:0] m_req_pc = '0;
    int          m_out = 0;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];

    task automatic model_reset();
        m_pc = 32'h0; m_req_pc = '0; m_out = 0;
        mq_pc.delete(); mq_ins.delete();
    endtask

    function automatic logic exp_req();
        return !rst && (m_out == 0) && (mq_pc.size() < DEPTH) && !redirect_valid;
    endfunction

    task automatic model_update();
        logic rq;
        if (rst) begin
            model_reset();
            return;
        end
        rq = exp_req();
        if (redirect_valid) begin
            m_pc = {redirect_pc[31:2], 2'b00};
            mq_pc.delete(); mq_ins.delete();
            m_out = (m_out != 0 && !imem_rvalid) ? 2 : 0;
        end else begin
            if (mq_pc.size() > 0 && !stall) begin
                void'(mq_pc.pop_front());
                void'(mq_ins.pop_front());
            end
            if (m_out == 1 && imem_rvalid) begin
                mq_pc.push_back(m_req_pc);
                mq_ins.push_back(imem_rdata);
            end
            if (m_out == 0 && rq && imem_gnt) begin
                m_req_pc = m_pc;
                m_pc     = m_pc + 32'd4;
                m_out    = 1;
            end else if (m_out != 0 && imem_rvalid) begin
                m_out = 0;
            end
        end
    endtask

    task automatic mem_posedge();
        if (imem_rvalid) mem_pend = 0;
        if (req_s && imem_gnt) begin
            mem_pend = 1;
            mem_addr = addr_s;
            mem_wait = $urandom_range(lat_max, lat_min) - 1;
        end
    endtask

    task automatic mem_drive();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        imem_rdata  = $urandom();
        if (mem_pend) begin
            if (mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ key;
            end else begin
                mem_wait--;
            end
        end else begin
            imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
        end
    endtask

    // Per-cycle history of DUT outputs, indexed from the cycle a test marks as 0
    int          cyc = 1000;
    logic        reqh [64];
    logic [31:0] addrh[64];
    logic        vh   [64];
    logic [31:0] pch  [64];
    logic [31:0] insh [64];
    logic        poph [64];
    logic        busyh[64];

    task automatic step();
        @(posedge clk);
        model_update();
        mem_posedge();
        #1;
        rst            = drv_rst;
        stall          = drv_stall;
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        if (start_log) begin
            cyc = 0;
            start_log = 0;
        end
        #1;
        mem_drive();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    always @(negedge clk) begin
        req_s  = imem_req;
        addr_s = imem_addr;
        if (cyc >= 0 && cyc < 64) begin
            reqh[cyc]  = imem_req;
            addrh[cyc] = imem_addr;
            vh[cyc]    = if_valid;
            pch[cyc]   = if_pc;
            insh[cyc]  = if_instr;
            poph[cyc]  = if_valid && !stall && !redirect_valid;
            busyh[cyc] = busy;
        end
        cyc++;
        if (!rst) begin
            check("imem_req", {31'b0, imem_req}, {31'b0, exp_req()});
            if (exp_req()) check("imem_addr", imem_addr, m_pc);
            check("busy", {31'b0, busy}, {31'b0, m_out != 0});
            check("if_valid", {31'b0, if_valid}, {31'b0, mq_pc.size() != 0});
            if (mq_pc.size() != 0) begin
                check("if_pc", if_pc, mq_pc[0]);
                check("if_instr", if_instr, mq_ins[0]);
            end
        end
    end

    logic [31:0] pq_pc[$];
    logic [31:0] pq_ins[$];

    task automatic collect(input int n);
        pq_pc.delete(); pq_ins.delete();
        for (int i = 0; i < n && i < 64; i++) begin
            if (poph[i]) begin
                pq_pc.push_back(pch[i]);
                pq_ins.push_back(insh[i]);
            end
        end
    endtask

    function automatic logic [31:0] pop_pc(input int i);
        return (i < pq_pc.size()) ? pq_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_ins(input int i);
        return (i < pq_ins.size()) ? pq_ins[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset(input bit clear_mem);
        drv_rst = 1'b1; drv_stall = 1'b0; drv_redir = 1'b0; drv_rpc = '0;
        run(3);
        check("reset imem_req", {31'b0, imem_req}, 32'd0);
        check("reset if_valid", {31'b0, if_valid}, 32'd0);
        check("reset if_pc", if_pc, 32'd0);
        check("reset if_instr", if_instr, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset imem_addr", imem_addr, 32'h0000_0000);
        if (clear_mem) mem_pend = 0;
        drv_rst   = 1'b0;
        start_log = 1;
    endtask

    initial begin
        int cnt;

        // 1: streaming with a 1-cycle memory
        key = '0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(1);
        run(10);
        @(negedge clk); #1;
        collect(10);
        check("t1 pop0 pc", pop_pc(0), 32'h0);
        check("t1 pop1 pc", pop_pc(1), 32'h4);
        check("t1 pop2 pc", pop_pc(2), 32'h8);
        check("t1 pop2 instr", pop_ins(2), 32'h8);
        cnt = 0;
        for (int i = 0; i < 10; i++) cnt += int'(reqh[i]);
        check("t1 req pulses in 10 cycles", cnt, 5);
        check("t1 req idle cycle 1", {31'b0, reqh[1]}, 32'd0);

        // 2: stall from the first valid for 10 cycles
        do_reset(1);
        run(2);
        drv_stall = 1'b1;
        run(10);
        drv_stall = 1'b0;
        run(10);
        @(negedge clk); #1;
        collect(22);
        cnt = 0;
        for (int i = 2; i < 12; i++) cnt += int'(vh[i] && pch[i] == 32'h0);
        check("t2 head held during stall", cnt, 10);
        cnt = 0;
        for (int i = 4; i < 12; i++) cnt += int'(reqh[i]);
        check("t2 no req while full", cnt, 0);
        check("t2 pop0 pc", pop_pc(0), 32'h0);
        check("t2 pop1 pc", pop_pc(1), 32'h4);
        check("t2 pop2 pc", pop_pc(2), 32'h8);

        // 3: redirect while waiting for 0x8, stale response two cycles later
        lat_min = 3; lat_max = 3;
        do_reset(1);
        run(9);
        drv_redir = 1'b1; drv_rpc = 32'h100;
        run(1);
        drv_redir = 1'b0;
        run(12);
        @(negedge clk); #1;
        collect(22);
        check("t3 busy in drain", {31'b0, busyh[10]}, 32'd1);
        check("t3 req to target", {31'b0, reqh[12]}, 32'd1);
        check("t3 addr to target", addrh[12], 32'h100);
        check("t3 pop2 pc", pop_pc(2), 32'h100);
        cnt = 0;
        for (int i = 0; i < 22; i++) cnt += int'(vh[i] && pch[i] == 32'h8);
        check("t3 stale 0x8 never valid", cnt, 0);

        // 4: misaligned redirect in the same cycle as rvalid
        lat_min = 1; lat_max = 1;
        do_reset(1);
        run(1);
        drv_redir = 1'b1; drv_rpc = 32'h203;
        run(1);
        drv_redir = 1'b0;
        run(8);
        @(negedge clk); #1;
        collect(10);
        check("t4 addr after redirect", addrh[2], 32'h200);
        check("t4 req after redirect", {31'b0, reqh[2]}, 32'd1);
        check("t4 discarded response", {31'b0, vh[2]}, 32'd0);
        check("t4 pop0 pc", pop_pc(0), 32'h200);
        check("t4 pop0 instr", pop_ins(0), 32'h200);

        // 5: pc wrap at the top of the address space
        do_reset(1);
        drv_redir = 1'b1; drv_rpc = 32'hFFFF_FFFC;
        run(1);
        drv_redir = 1'b0;
        run(6);
        @(negedge clk); #1;
        collect(7);
        check("t5 no req on redirect", {31'b0, reqh[0]}, 32'd0);
        check("t5 addr top", addrh[1], 32'hFFFF_FFFC);
        check("t5 addr wrapped", addrh[3], 32'h0);
        check("t5 pop0 pc", pop_pc(0), 32'hFFFF_FFFC);
        check("t5 pop1 pc", pop_pc(1), 32'h0);

        // 6: reset while waiting; the late response must be ignored
        lat_min = 3; lat_max = 3;
        do_reset(1);
        run(1);
        drv_rst = 1'b1;
        run(2);
        drv_rst = 1'b0;
        start_log = 1;
        run(8);
        @(negedge clk); #1;
        collect(8);
        check("t6 first req", {31'b0, reqh[0]}, 32'd1);
        check("t6 first addr", addrh[0], 32'h0);
        check("t6 not busy", {31'b0, busyh[0]}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 5; i++) cnt += int'(vh[i]);
        check("t6 no valid before response", cnt, 0);
        check("t6 pop0 pc", pop_pc(0), 32'h0);

        // Randomized run
        key = $urandom(); gnt_pct = 70; lat_min = 1; lat_max = 4;
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < 3) begin
                drv_rst = 1'b1;
                run(2);
                drv_rst = 1'b0;
            end
            drv_stall = ($urandom_range(99) < 30);
            drv_redir = ($urandom_range(99) < 7);
            drv_rpc   = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
            step();
        end
        drv_stall = 1'b0; drv_redir = 1'b0;
        run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
